// File: rtl/shifter_pkg.sv
// Shared codes for the operand-2 shifter: shift-type field values,
// single-step operations, FSM state encodings and the step limit.
package shifter_pkg;

  // Shift type field OPERAND2[6:5]
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // One-bit step operations performed by shift_step
  typedef enum logic [2:0] {
    OP_LSL = 3'd0,
    OP_LSR = 3'd1,
    OP_ASR = 3'd2,
    OP_ROR = 3'd3,
    OP_RRX = 3'd4
  } step_op_t;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  // Longest operation: register LSL/LSR by 33 or more
  localparam int MAX_STEPS = 33;

endpackage

// File: rtl/shifter_operand_unit_shift_step.sv
// One-bit shift/rotate step: moves the value one position and reports
// the bit that fell off the end as the new carry.
module shift_step
  import shifter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] value,
  input  logic              carry,
  input  step_op_t          op,
  input  logic              cin,
  output logic [DATA_W-1:0] next_value,
  output logic              next_carry
);

  // Single step for every operation; unknown codes leave value and carry alone
  always_comb begin
    next_value = value;
    next_carry = carry;
    case (op)
      OP_LSL: begin
        next_value = {value[DATA_W-2:0], 1'b0};
        next_carry = value[DATA_W-1];
      end
      OP_LSR: begin
        next_value = {1'b0, value[DATA_W-1:1]};
        next_carry = value[0];
      end
      OP_ASR: begin
        next_value = {value[DATA_W-1], value[DATA_W-1:1]};
        next_carry = value[0];
      end
      OP_ROR: begin
        next_value = {value[0], value[DATA_W-1:1]};
        next_carry = value[0];
      end
      OP_RRX: begin
        next_value = {cin, value[DATA_W-1:1]};
        next_carry = value[0];
      end
      default: begin
        next_value = value;
        next_carry = carry;
      end
    endcase
  end

endmodule

// File: rtl/shifter_operand_unit.sv
// Iterative ARM operand-2 generator. Decodes the operand-2 field into a
// start value, a step operation and a step count, then shifts one bit
// per clock until the count is exhausted.
//
// Handshake: START is sampled only in IDLE; the edge that samples it is
// the accepting edge. BUSY is high for the N shifting cycles that follow,
// then DONE is high for exactly one cycle (cycle N+1 after the accept)
// and SHIFTER_OPERAND/SHIFTER_CARRY are valid from that cycle and held
// until the next accept. START while BUSY or DONE is dropped, not queued.
module shifter_operand_unit
  import shifter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              IMM_FORM,
  input  logic [11:0]       OPERAND2,
  input  logic [DATA_W-1:0] RM_VAL,
  input  logic [DATA_W-1:0] RS_VAL,
  input  logic              CIN,
  output logic [DATA_W-1:0] SHIFTER_OPERAND,
  output logic              SHIFTER_CARRY,
  output logic              BUSY,
  output logic              DONE,
  output logic [1:0]        state_dbg
);

  logic [1:0]        state;
  logic [DATA_W-1:0] work;
  logic              work_carry;
  logic              cin_q;
  step_op_t          op;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] res;
  logic              res_carry;

  logic [DATA_W-1:0] ld_val;
  step_op_t          ld_op;
  logic [CNT_W-1:0]  ld_cnt;

  logic [DATA_W-1:0] step_val;
  logic              step_carry;

  logic [4:0] sh;
  logic [1:0] sh_type;
  logic [7:0] rs_n;
  logic       unused_bits;

  assign sh          = OPERAND2[11:7];
  assign sh_type     = OPERAND2[6:5];
  assign rs_n        = RS_VAL[7:0];
  // Rm index and the upper Rs byte play no part in the shift itself
  assign unused_bits = ^{RS_VAL[DATA_W-1:8], OPERAND2[3:0]};

  // Decode operand-2 into start value, step operation and step count
  always_comb begin
    ld_val = RM_VAL;
    ld_op  = OP_LSL;
    ld_cnt = '0;
    if (IMM_FORM) begin
      ld_val = {{(DATA_W-8){1'b0}}, OPERAND2[7:0]};
      ld_op  = OP_ROR;
      ld_cnt = CNT_W'({OPERAND2[11:8], 1'b0});
    end else if (!OPERAND2[4]) begin
      case (sh_type)
        SH_LSL: begin
          ld_op  = OP_LSL;
          ld_cnt = CNT_W'(sh);
        end
        SH_LSR: begin
          ld_op  = OP_LSR;
          ld_cnt = (sh == 5'd0) ? CNT_W'(DATA_W) : CNT_W'(sh);
        end
        SH_ASR: begin
          ld_op  = OP_ASR;
          ld_cnt = (sh == 5'd0) ? CNT_W'(DATA_W) : CNT_W'(sh);
        end
        default: begin
          // ROR #0 encodes RRX: a single step pulling C into bit 31
          ld_op  = (sh == 5'd0) ? OP_RRX : OP_ROR;
          ld_cnt = (sh == 5'd0) ? CNT_W'(1) : CNT_W'(sh);
        end
      endcase
    end else if (!OPERAND2[7] && (rs_n != 8'd0)) begin
      case (sh_type)
        SH_LSL: begin
          ld_op  = OP_LSL;
          ld_cnt = (rs_n > 8'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : CNT_W'(rs_n);
        end
        SH_LSR: begin
          ld_op  = OP_LSR;
          ld_cnt = (rs_n > 8'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : CNT_W'(rs_n);
        end
        SH_ASR: begin
          // Past 32 steps the value is all sign bits; more steps change nothing
          ld_op  = OP_ASR;
          ld_cnt = (rs_n > 8'(DATA_W)) ? CNT_W'(DATA_W) : CNT_W'(rs_n);
        end
        default: begin
          // Multiples of 32 rotate a full turn so carry ends as Rm[31]
          ld_op  = OP_ROR;
          ld_cnt = (rs_n[4:0] == 5'd0) ? CNT_W'(DATA_W) : CNT_W'(rs_n[4:0]);
        end
      endcase
    end
    // Register shift by 0 and the non-data-processing form fall through
    // as LSL #0: Rm with carry unchanged.
  end

  shift_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .value      (work),
    .carry      (work_carry),
    .op         (op),
    .cin        (cin_q),
    .next_value (step_val),
    .next_carry (step_carry)
  );

  // Controller: load on accept, step while counting, publish result into FIN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      work       <= '0;
      work_carry <= 1'b0;
      cin_q      <= 1'b0;
      op         <= OP_LSL;
      cnt        <= '0;
      res        <= '0;
      res_carry  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            work       <= ld_val;
            work_carry <= CIN;
            cin_q      <= CIN;
            op         <= ld_op;
            cnt        <= ld_cnt;
            if (ld_cnt == '0) begin
              state     <= ST_FIN;
              res       <= ld_val;
              res_carry <= CIN;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work       <= step_val;
          work_carry <= step_carry;
          cnt        <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= ST_FIN;
            res       <= step_val;
            res_carry <= step_carry;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign SHIFTER_OPERAND = res;
  assign SHIFTER_CARRY   = res_carry;
  assign BUSY            = (state == ST_SHIFT);
  assign DONE            = (state == ST_FIN);
  assign state_dbg       = state;

endmodule

// File: tb/tb_shifter_operand_unit.sv
// Bench for shifter_operand_unit: directed operand-2 vectors with
// hand-computed results, an arithmetic reference model, and a per-cycle
// compare of BUSY/DONE/result against the expected timeline.
module tb_shifter_operand_unit;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic        IMM_FORM;
  logic [11:0] OPERAND2;
  logic [31:0] RM_VAL;
  logic [31:0] RS_VAL;
  logic        CIN;
  logic [31:0] SHIFTER_OPERAND;
  logic        SHIFTER_CARRY;
  logic        BUSY;
  logic        DONE;
  logic [1:0]  dbg_state;

  shifter_operand_unit #(
    .DATA_W(32),
    .CNT_W (6)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .START           (START),
    .IMM_FORM        (IMM_FORM),
    .OPERAND2        (OPERAND2),
    .RM_VAL          (RM_VAL),
    .RS_VAL          (RS_VAL),
    .CIN             (CIN),
    .SHIFTER_OPERAND (SHIFTER_OPERAND),
    .SHIFTER_CARRY   (SHIFTER_CARRY),
    .BUSY            (BUSY),
    .DONE            (DONE),
    .state_dbg       (dbg_state)
  );

  // ---------------- clock / reset / edge counter ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int e = 0;
  always @(posedge CLK) e <= e + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];      // {carry, result} per accepted operation
  logic        active   = 1'b0;
  int          acc_edge = 0;
  int          n_steps  = 0;
  logic [31:0] held_res = 32'd0;
  logic        held_c   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void shift_by(input logic [1:0] t, input logic [31:0] x, input int a,
                                   output logic [31:0] r, output logic c);
    case (t)
      2'b00: begin
        if (a < 32)       begin r = x << a;  c = x[32-a]; end
        else if (a == 32) begin r = 32'd0;   c = x[0];    end
        else              begin r = 32'd0;   c = 1'b0;    end
      end
      2'b01: begin
        if (a < 32)       begin r = x >> a;  c = x[a-1];  end
        else if (a == 32) begin r = 32'd0;   c = x[31];   end
        else              begin r = 32'd0;   c = 1'b0;    end
      end
      2'b10: begin
        if (a < 32) begin r = $signed(x) >>> a; c = x[a-1]; end
        else        begin r = {32{x[31]}};      c = x[31];  end
      end
      default: begin
        if (a == 32) begin r = x; c = x[31]; end
        else begin r = (x >> a) | (x << (32 - a)); c = x[a-1]; end
      end
    endcase
  endfunction

  function automatic void model(input logic imm, input logic [11:0] op2, input logic [31:0] rm,
                                input logic [31:0] rs, input logic cin,
                                output logic [31:0] r, output logic c, output int n);
    int          a;
    logic [1:0]  t;
    logic [31:0] v;
    t = op2[6:5];
    r = rm;
    c = cin;
    n = 0;
    if (imm) begin
      a = 2 * int'(op2[11:8]);
      v = {24'd0, op2[7:0]};
      n = a;
      r = v;
      if (a != 0) begin
        r = (v >> a) | (v << (32 - a));
        c = r[31];
      end
    end else if (!op2[4]) begin
      a = int'(op2[11:7]);
      if (t == 2'b11 && a == 0) begin
        r = {cin, rm[31:1]};
        c = rm[0];
        n = 1;
      end else begin
        if ((t == 2'b01 || t == 2'b10) && a == 0) a = 32;
        n = a;
        if (a != 0) shift_by(t, rm, a, r, c);
      end
    end else if (!op2[7]) begin
      a = int'(rs[7:0]);
      if (a != 0) begin
        case (t)
          2'b00, 2'b01: n = (a > 33) ? 33 : a;
          2'b10:        n = (a > 32) ? 32 : a;
          default:      n = ((a % 32) == 0) ? 32 : (a % 32);
        endcase
        if (t == 2'b11) a = n;
        shift_by(t, rm, a, r, c);
      end
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    logic        exp_busy;
    logic        exp_done;
    logic [32:0] ent;
    exp_busy = active && (e >= acc_edge) && (e < acc_edge + n_steps);
    exp_done = active && (e == acc_edge + n_steps);
    check("busy", 32'(BUSY), 32'(exp_busy));
    check("done", 32'(DONE), 32'(exp_done));
    if (exp_done) begin
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL exp_q: DONE cycle with no expected entry (t=%0t)", $time);
      end else begin
        ent      = exp_q.pop_front();
        held_res = ent[31:0];
        held_c   = ent[32];
      end
      active = 1'b0;
    end
    if (!exp_busy) begin
      check("result", SHIFTER_OPERAND, held_res);
      check("carry", 32'(SHIFTER_CARRY), 32'(held_c));
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one request; returns on the first negedge after the accept edge.
  task automatic start_op(input logic imm, input logic [11:0] op2, input logic [31:0] rm,
                          input logic [31:0] rs, input logic cin,
                          output logic [31:0] r, output logic c, output int n);
    @(negedge CLK);
    model(imm, op2, rm, rs, cin, r, c, n);
    IMM_FORM = imm;
    OPERAND2 = op2;
    RM_VAL   = rm;
    RS_VAL   = rs;
    CIN      = cin;
    exp_q.push_back({c, r});
    acc_edge = e + 1;
    n_steps  = n;
    active   = 1'b1;
    START    = 1'b1;
    @(negedge CLK);
    START    = 1'b0;
  endtask

  // Full operation; poke>0 re-raises START so it is sampled at accept+poke.
  task automatic run_op(input string name, input logic imm, input logic [11:0] op2,
                        input logic [31:0] rm, input logic [31:0] rs, input logic cin,
                        input logic [31:0] lit_r, input logic lit_c, input int lit_n,
                        input int poke);
    logic [31:0] r;
    logic        c;
    int          n;
    start_op(imm, op2, rm, rs, cin, r, c, n);
    check({name, "_model_res"}, r, lit_r);
    check({name, "_model_steps"}, 32'(n), 32'(lit_n));
    for (int i = 1; i <= n; i++) begin
      if (poke == i) START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
    @(negedge CLK);
    check({name, "_res"}, SHIFTER_OPERAND, lit_r);
    check({name, "_carry"}, 32'(SHIFTER_CARRY), 32'(lit_c));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    logic        c;
    int          n;
    RESET_N  = 1'b0;
    START    = 1'b0;
    IMM_FORM = 1'b0;
    OPERAND2 = 12'h000;
    RM_VAL   = 32'd0;
    RS_VAL   = 32'd0;
    CIN      = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_res", SHIFTER_OPERAND, 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    //      name         imm   op2      rm            rs     cin   result        c     N   poke
    run_op("imm_ror8",   1'b1, 12'h4FF, 32'h0,        32'd0, 1'b0, 32'hFF000000, 1'b1, 8,  0);
    run_op("imm_ror2",   1'b1, 12'h101, 32'h0,        32'd0, 1'b1, 32'h40000000, 1'b0, 2,  0);
    run_op("imm_rot0",   1'b1, 12'h0A5, 32'h0,        32'd0, 1'b1, 32'h000000A5, 1'b1, 0,  0);
    run_op("reg_lsl32",  1'b0, 12'h010, 32'h00000001, 32'd32, 1'b0, 32'h0,       1'b1, 32, 0);
    run_op("reg_lsl33",  1'b0, 12'h010, 32'h00000001, 32'd33, 1'b0, 32'h0,       1'b0, 33, 0);
    run_op("reg_lsl0",   1'b0, 12'h010, 32'h00000001, 32'd0,  1'b1, 32'h00000001, 1'b1, 0, 0);
    run_op("imm_asr0",   1'b0, 12'h040, 32'h80000000, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 32, 0);
    run_op("rrx",        1'b0, 12'h060, 32'h00000003, 32'd0, 1'b1, 32'h80000001, 1'b1, 1,  0);
    run_op("reg_ror32",  1'b0, 12'h070, 32'h80000001, 32'h20, 1'b0, 32'h80000001, 1'b1, 32, 0);
    run_op("reg_ror4",   1'b0, 12'h070, 32'h0000000F, 32'd4, 1'b0, 32'hF0000000, 1'b1, 4,  0);
    run_op("imm_lsl4",   1'b0, 12'h200, 32'h12345678, 32'd0, 1'b0, 32'h23456780, 1'b1, 4,  2);
    run_op("imm_lsr1",   1'b0, 12'h0A0, 32'h80000001, 32'd0, 1'b0, 32'h40000000, 1'b1, 1,  0);
    run_op("non_dp",     1'b0, 12'h090, 32'hDEADBEEF, 32'd5, 1'b0, 32'hDEADBEEF, 1'b0, 0,  0);
    run_op("reg_asr200", 1'b0, 12'h050, 32'h40000000, 32'd200, 1'b1, 32'h0,      1'b0, 32, 0);
    run_op("reg_lsr32",  1'b0, 12'h030, 32'hFFFFFFFF, 32'd32, 1'b0, 32'h0,       1'b1, 32, 0);
    run_op("reg_lsr40",  1'b0, 12'h030, 32'hFFFFFFFF, 32'd40, 1'b1, 32'h0,       1'b0, 33, 0);
    run_op("rs_hi_bits", 1'b0, 12'h010, 32'h00000003, 32'hFFFF0001, 1'b0, 32'h00000006, 1'b0, 1, 0);

    // Abort an ASR #32 mid-shift with reset: outputs clear at once, no DONE
    start_op(1'b0, 12'h040, 32'h80000000, 32'd0, 1'b0, r, c, n);
    repeat (5) @(negedge CLK);
    @(posedge CLK);
    #2;
    active   = 1'b0;
    exp_q.delete();
    held_res = 32'd0;
    held_c   = 1'b0;
    RESET_N  = 1'b0;
    #1;
    check("rst_mid_res", SHIFTER_OPERAND, 32'd0);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (40) @(negedge CLK);

    run_op("after_rst",  1'b1, 12'h4FF, 32'h0,        32'd0, 1'b0, 32'hFF000000, 1'b1, 8,  0);

    repeat (3) @(negedge CLK);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shifter_operand_unit.md
Name: shifter_operand_unit

Overview:
Iterative ARM data-processing operand-2 generator, directly upstream of the ALU. It produces the ALU right operand (shifter_operand) and the shifter carry-out from the instruction's operand-2 field, Rm, Rs and the current C flag. It shifts one bit per clock under a START/DONE handshake and uses no barrel shifter.

Parameters:
DATA_W, 32, datapath width (only 32 supported)
CNT_W, 6, step counter width (max 33 steps)

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
START  in  1  request; sampled only in IDLE
IMM_FORM  in  1  instruction I bit; 1 = rotated 8-bit immediate
OPERAND2  in  12  instruction bits [11:0]
RM_VAL  in  32  value of Rm
RS_VAL  in  32  value of Rs; only [7:0] used
CIN  in  1  current CPSR C flag
SHIFTER_OPERAND  out  32  result, feeds ALU right operand
SHIFTER_CARRY  out  1  shifter carry-out
BUSY  out  1  high while shifting
DONE  out  1  one-cycle pulse; outputs valid

Interface decision: one clock, CLK. Reset RESET_N is asynchronous and active-low.

Behaviour:
- Reset: state IDLE; SHIFTER_OPERAND=0, SHIFTER_CARRY=0, BUSY=0, DONE=0, count=0. Reset mid-operation aborts the operation and no DONE is issued.
- FSM states: IDLE, SHIFT, FIN.
- IDLE with START=1: load working register, carry and step count N (rules below). Go to SHIFT if N>0, else FIN.
- SHIFT, each clock:
  - one step; carry = bit shifted out; count--.
  - Leave for FIN on the step where count==1.
  - BUSY=1 throughout.
- FIN: DONE=1 for one cycle, then IDLE.
- Latency: DONE is high in cycle N+1 after the accepting edge.
- START in SHIFT or FIN is ignored; it is not queued.
- Outputs hold the last result until the next accept.
- Step ops: LSL (shift in 0), LSR (shift in 0), ASR (shift in bit 31), ROR (bit 0 into bit 31), RRX (CIN into bit 31).
- Immediate form (IMM_FORM=1):
  - Working register = zero-extended OPERAND2[7:0]; ROR; N = 2*OPERAND2[11:8]; initial carry = CIN.
  - So rot=0 gives carry CIN, otherwise carry = result[31].
- Immediate shift (IMM_FORM=0, OPERAND2[4]=0): sh = OPERAND2[11:7], type = OPERAND2[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); initial carry = CIN.
  - LSL: N = sh.
  - LSR: N = (sh==0) ? 32 : sh.
  - ASR: N = (sh==0) ? 32 : sh.
  - ROR: sh==0 means RRX with N=1; otherwise N = sh.
- Register shift (OPERAND2[4]=1, OPERAND2[7]=0): n = RS_VAL[7:0]; initial carry = CIN; n==0 gives N=0 for all types.
  - LSL/LSR: N = min(n,33). Step 32 yields 0 with carry = last bit out; step 33 yields carry 0.
  - ASR: N = min(n,32).
  - ROR: N = (n[4:0]==0) ? 32 : n[4:0]. This makes n=32 return Rm with carry Rm[31].
- OPERAND2[4]=1 with OPERAND2[7]=1 (not data-processing): treated as LSL #0, i.e. N=0, result Rm, carry CIN.
- No arithmetic wider than 32 bits; counter saturation is never exercised because N ≤ 33.

Decomposition:
- Package shifter_pkg: shift type codes (SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11), step-op enum including RRX, FSM state encodings, MAX_STEPS=33.
- One combinational sub-module, shift_step. Inputs: value, carry, step op, CIN. Outputs: next value, next carry.
- Step-count decode stays in the top level.

Test Plan:
- IMM_FORM=1, OPERAND2=12'h4FF, CIN=0 -> SHIFTER_OPERAND=32'hFF000000, SHIFTER_CARRY=1, DONE 9 cycles after accept.
- Register LSL, RM=32'h00000001: RS=32 -> 0, carry 1; RS=33 -> 0, carry 0; RS=0, CIN=1 -> 32'h00000001, carry 1, DONE next cycle.
- Immediate ASR #0 (OPERAND2=12'h040), RM=32'h80000000 -> 32'hFFFFFFFF, carry 1, DONE after 33 cycles, BUSY high for 32 cycles.
- RRX (OPERAND2=12'h060), CIN=1, RM=32'h00000003 -> 32'h80000001, carry 1; ROR register RS=8'h20, RM=32'h80000001 -> 32'h80000001, carry 1.
- Pulse START during SHIFT -> ignored; the first result is unchanged and exactly one DONE is seen.
- Assert RESET_N=0 mid-SHIFT -> outputs 0 immediately, no DONE; a new START afterwards completes normally.
